simd_writeback: RTL and testbench
=================================

Name: simd_writeback

Overview:
- Output stage directly downstream of the SIMD bilinear downscale core.
- Accepts N-lane 8-bit pixel vectors and packs them into a DST_W x DST_H destination buffer in raster order.
- Signals frame completion and exposes the buffer to the host through a 1-cycle-latency read port, so results are checked through ports rather than internal signals.
- Also reports frame cycle count and overflow status.

Parameters:
- DST_W, 16, destination width in pixels
- DST_H, 16, destination height in pixels
- N, 4, SIMD lanes per input vector (1..8)
- AW, 16, host read address width; DST_W*DST_H <= 2**AW

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle pulse: arm/restart a frame
- in_valid  in  1  core presents a pixel vector
- in_ready  out  1  block accepts vector this cycle
- in_data  in  N*8  lane k at bits [8k+7:8k]
- in_mask  in  N  lane k carries a valid pixel when bit k=1
- rd_en  in  1  host read request
- rd_addr  in  AW  linear address row*DST_W+col
- rd_data  out  8  read data, one cycle after rd_en
- rd_valid  out  1  rd_en delayed one cycle
- frame_done  out  1  level, high in DONE state
- pix_count  out  AW+1  pixels written this frame
- cyc_count  out  32  cycles spent in ACTIVE, saturating at 2^32-1
- ovf  out  1  sticky: lanes dropped past end of frame

Behaviour:
- Reset (async assert, sync-to-clk deassert use): state IDLE; in_ready=0, frame_done=0, pix_count=0, cyc_count=0, ovf=0, rd_data=0, rd_valid=0. Buffer contents are not reset.
- States and transitions:
  - IDLE -> ACTIVE on frame_start.
  - ACTIVE -> DONE on the cycle the accepted vector makes pix_count reach DEPTH=DST_W*DST_H.
  - DONE -> ACTIVE on frame_start.
  - frame_start in ACTIVE restarts the frame in place.
- Entering ACTIVE (including restart): wr_ptr=0, pix_count=0, cyc_count=0, ovf=0, frame_done=0 the next cycle.
- in_ready = (state==ACTIVE); combinational from state only, never from in_valid.
- Transfer: in_valid & in_ready at a rising edge.
- Lane compaction: set lanes are written in ascending lane order. The j-th set lane (j from 0) goes to address wr_ptr+j. wr_ptr and pix_count advance by popcount(in_mask).
- Non-contiguous masks are legal, e.g. mask 4'b1010 writes lane1 to wr_ptr and lane3 to wr_ptr+1.
- A transfer with in_mask=0 is accepted with no effect.
- End-of-frame boundary: lanes whose target address is >= DEPTH are dropped and set ovf. The remaining lanes are written, and the state moves to DONE in the same edge.
- frame_done rises the cycle after the last pixel's write edge; in_ready falls on that same cycle.
- cyc_count increments every cycle in ACTIVE, including the cycle of the final transfer. It holds in DONE and IDLE.
- Host read:
  - rd_data <= buf[rd_addr], registered; valid in any state.
  - rd_addr >= DEPTH returns 8'h00.
  - A read and a write to the same address on the same edge return the old data (read-before-write).
- frame_start coinciding with a transfer: the restart wins and the vector is discarded.
- Async reset mid-frame: immediate return to IDLE; partial buffer contents are retained and readable.
- Buffer: DEPTH x 8 register array with N write ports (lane-compacted) and 1 read port. No pipeline inside the accept path, so a full-rate stream sustains 1 vector/cycle.

Test Plan:
- Reset, frame_start, then 64 vectors with in_mask=4'hF carrying pixels p=(addr*3)&255 -> frame_done high the cycle after the 64th transfer; pix_count=256; cyc_count=64; ovf=0. Host reads addr 0..255 return (addr*3)&255 with rd_valid one cycle after rd_en.
- Random in_valid gaps (30% idle) over the same frame -> identical buffer contents; cyc_count equals the number of ACTIVE cycles including gaps; in_ready stays 1 until done.
- Masks 4'b1010 and 4'b0000 interleaved with full vectors -> only set lanes stored, compacted; pix_count advances by 2 and 0 respectively.
- Frame of 255 pixels followed by a vector with mask 4'hF -> lane0 written at addr 255, lanes1-3 dropped; ovf=1; DONE reached; a subsequent frame_start clears ovf.
- frame_start asserted at pix_count=100 concurrently with a valid transfer -> that vector discarded; pix_count=0 and cyc_count=0 next cycle; new frame completes normally.
- rst_n pulled low mid-frame between clock edges -> in_ready=0 and frame_done=0 immediately; a read of addr 10 after release returns the value written before the reset; read of addr 300 returns 0.

Source files
------------

// File: rtl/simd_writeback.sv
// simd_writeback: lane-compacting writer of N-lane pixel vectors into a DST_W x DST_H raster buffer; ports: stream in (in_valid/in_ready/in_data/in_mask), host read (rd_en/rd_addr/rd_data/rd_valid), status (frame_done/pix_count/cyc_count/ovf)
module simd_writeback #(
  parameter int DST_W = 16,
  parameter int DST_H = 16,
  parameter int N = 4,
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*8-1:0]  in_data,
  input  logic [N-1:0]    in_mask,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [7:0]      rd_data,
  output logic            rd_valid,
  output logic            frame_done,
  output logic [AW:0]     pix_count,
  output logic [31:0]     cyc_count,
  output logic            ovf
);
  localparam int DEPTH = DST_W * DST_H;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW:0] addr [N];
  logic [AW:0] cnt;
  logic [N-1:0] we;
  logic drop;
  logic xfer;
  assign in_ready = state == ACTIVE;
  assign frame_done = state == DONE;
  assign xfer = in_valid & in_ready & ~frame_start;
  always_comb begin
    cnt = pix_count;
    drop = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr[k] = cnt;
      we[k] = xfer & in_mask[k] & (cnt < LAST);
      drop = drop | (xfer & in_mask[k] & (cnt >= LAST));
      cnt = cnt + (AW+1)'(in_mask[k]);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (we[k]) mem[addr[k][IW-1:0]] <= in_data[8*k +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pix_count <= '0;
      cyc_count <= '0;
      ovf <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= {1'b0, rd_addr} < LAST ? mem[rd_addr[IW-1:0]] : 8'h00;
      if (frame_start) begin
        state <= ACTIVE;
        pix_count <= '0;
        cyc_count <= '0;
        ovf <= 1'b0;
      end else if (state == ACTIVE) begin
        cyc_count <= cyc_count == '1 ? cyc_count : cyc_count + 32'd1;
        if (xfer) begin
          pix_count <= cnt >= LAST ? LAST : cnt;
          ovf <= ovf | drop;
          if (cnt >= LAST) state <= DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_simd_writeback.sv
// tb_simd_writeback: directed self-checking bench for simd_writeback
module tb_simd_writeback;
  logic clk = 0, rst_n = 0, frame_start = 0, in_valid = 0, rd_en = 0;
  logic in_ready, rd_valid, frame_done, ovf;
  logic [31:0] in_data = 0;
  logic [3:0] in_mask = 0;
  logic [15:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic [16:0] pix_count;
  logic [31:0] cyc_count;
  int n_chk = 0, n_ok = 0;
  always #5 clk = ~clk;
  simd_writeback dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_done(frame_done), .pix_count(pix_count), .cyc_count(cyc_count), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] px(input int m, input int a);
    case (m)
      0: return 8'((a * 3) & 255);
      1: return 8'(a * 7 + 1);
      2: return 8'(a ^ 'h5A);
      default: return 8'(a + 'h80);
    endcase
  endfunction
  function automatic logic [31:0] lanes(input int m, input int base);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = px(m, base + k);
    return d;
  endfunction
  task automatic vec(input logic [31:0] d, input logic [3:0] m);
    in_valid = 1;
    in_data = d;
    in_mask = m;
    tick;
    in_valid = 0;
    in_mask = 0;
  endtask
  task automatic frame(input int m, input int nv);
    for (int v = 0; v < nv; v++) vec(lanes(m, 4 * v), 4'hF);
  endtask
  task automatic start;
    frame_start = 1;
    tick;
    frame_start = 0;
  endtask
  task automatic rd(input int a, input logic [7:0] exp, input string tag);
    rd_en = 1;
    rd_addr = 16'(a);
    tick;
    rd_en = 0;
    chk(tag, rd_data, exp);
  endtask
  initial begin
    int act, sent, guard;
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_cyc", cyc_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_valid, 0);
    #5 rst_n = 1;
    tick;
    chk("idle_ready", in_ready, 0);
    start;
    chk("act_ready", in_ready, 1);
    chk("act_cyc0", cyc_count, 0);
    frame(0, 63);
    chk("pre_done", frame_done, 0);
    vec(lanes(0, 252), 4'hF);
    chk("f1_done", frame_done, 1);
    chk("f1_ready", in_ready, 0);
    chk("f1_pix", pix_count, 256);
    chk("f1_cyc", cyc_count, 64);
    chk("f1_ovf", ovf, 0);
    for (int a = 0; a < 256; a++) begin
      rd(a, px(0, a), "f1_rd");
      chk("f1_rvalid", rd_valid, 1);
    end
    tick;
    chk("rvalid_drop", rd_valid, 0);
    start;
    act = 0;
    sent = 0;
    guard = 0;
    while (sent < 64 && guard < 2000) begin
      chk("gap_ready", in_ready, 1);
      if ($urandom_range(0, 9) < 3) tick;
      else begin
        vec(lanes(1, 4 * sent), 4'hF);
        sent++;
      end
      act++;
      guard++;
    end
    chk("gap_sent", sent, 64);
    chk("gap_done", frame_done, 1);
    chk("gap_cyc", cyc_count, act);
    chk("gap_pix", pix_count, 256);
    rd(0, px(1, 0), "gap_rd0");
    rd(77, px(1, 77), "gap_rd77");
    rd(255, px(1, 255), "gap_rd255");
    start;
    vec(32'h44332211, 4'hF);
    chk("m_pix4", pix_count, 4);
    vec(32'hDDCCBBAA, 4'b1010);
    chk("m_pix6", pix_count, 6);
    vec(32'hFFFFFFFF, 4'b0000);
    chk("m_pix6z", pix_count, 6);
    vec(32'h88776655, 4'hF);
    chk("m_pix10", pix_count, 10);
    rd(3, 8'h44, "m_rd3");
    rd(4, 8'hBB, "m_rd4");
    rd(5, 8'hDD, "m_rd5");
    rd(6, 8'h55, "m_rd6");
    rd(9, 8'h88, "m_rd9");
    start;
    frame(2, 63);
    vec(lanes(2, 252), 4'b0111);
    chk("e_pix255", pix_count, 255);
    chk("e_notdone", frame_done, 0);
    chk("e_ovf0", ovf, 0);
    vec(32'hA3A2A1A0, 4'hF);
    chk("e_ovf1", ovf, 1);
    chk("e_done", frame_done, 1);
    chk("e_pix", pix_count, 256);
    rd(255, 8'hA0, "e_rd255");
    rd(254, px(2, 254), "e_rd254");
    start;
    chk("e_ovfclr", ovf, 0);
    chk("e_pixclr", pix_count, 0);
    chk("e_doneclr", frame_done, 0);
    frame(2, 25);
    chk("r_pix100", pix_count, 100);
    frame_start = 1;
    in_valid = 1;
    in_data = 32'hEEEEEEEE;
    in_mask = 4'hF;
    tick;
    frame_start = 0;
    in_valid = 0;
    in_mask = 0;
    chk("r_pix0", pix_count, 0);
    chk("r_cyc0", cyc_count, 0);
    rd(100, px(2, 100), "r_rd100");
    frame(0, 64);
    chk("r_done", frame_done, 1);
    chk("r_pix", pix_count, 256);
    chk("r_cyc", cyc_count, 65);
    start;
    frame(3, 5);
    chk("a_pix20", pix_count, 20);
    #2 rst_n = 0;
    #1;
    chk("a_ready", in_ready, 0);
    chk("a_done", frame_done, 0);
    chk("a_pix", pix_count, 0);
    chk("a_cyc", cyc_count, 0);
    #1 rst_n = 1;
    rd(10, px(3, 10), "a_rd10");
    chk("a_rvalid", rd_valid, 1);
    rd(300, 8'h00, "a_rd300");
    start;
    rd_en = 1;
    rd_addr = 0;
    vec(32'h44332211, 4'hF);
    rd_en = 0;
    chk("rbw_old", rd_data, px(3, 0));
    rd(0, 8'h11, "rbw_new");
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
